// File: rtl/lsu.sv
// Load/store unit: one op in flight, decodes EXU results into bus loads/stores or pass-through.
// Latency: non-memory/error ops 1 edge to out_valid; memory ops 1 edge to mem_req, out_valid 1 edge after ack.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; bus request held until mem_ack or timeout.
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] EXU_data,
    input  logic [31:0] store_data,
    input  logic [4:0]  lsu_op,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_out,
    output logic        lsu_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // Counter only needs to reach TIMEOUT-1: the cycle it would hit TIMEOUT is the error cycle.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] KIND_NONE  = 2'b00;
    localparam logic [1:0] KIND_LOAD  = 2'b01;
    localparam logic [1:0] KIND_STORE = 2'b10;

    state_t        state, state_nxt;
    logic [31:0]   addr_q;
    logic [31:0]   sdata_q;
    logic [4:0]    op_q;
    logic [4:0]    rd_q;
    logic [CW-1:0] cnt;
    logic [31:0]   wb_q;
    logic          err_q;

    // Decode of the incoming op, used only for the IDLE accept decision.
    logic [1:0] in_kind;
    logic [1:0] in_size;
    logic       in_misal;
    logic       in_mem;
    logic       timeout_hit;
    logic       is_store;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [3:0]  base_mask;

    assign in_kind  = lsu_op[4:3];
    assign in_size  = lsu_op[1:0];
    assign in_misal = ((in_size == 2'b01) && EXU_data[0]) ||
                      ((in_size == 2'b10) && (EXU_data[1:0] != 2'b00));
    assign in_mem   = ((in_kind == KIND_LOAD) || (in_kind == KIND_STORE)) &&
                      (in_size != 2'b11) && !in_misal;

    assign timeout_hit = (cnt == CNT_LAST);
    assign is_store    = (op_q[4:3] == KIND_STORE);

    // Handshake outputs decode straight from state so an async reset drops them at once.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign mem_req   = (state == REQ);

    assign wb_data = wb_q;
    assign rd_out  = rd_q;
    assign lsu_err = err_q;

    // Bus request fields: word-aligned address, lane-shifted data and strobes, driven only in REQ.
    always_comb begin
        base_mask = 4'b0000;
        case (op_q[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            2'b10:   base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_we    = mem_req && is_store;
        mem_wdata = (mem_req && is_store) ? (sdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
        mem_wmask = (mem_req && is_store) ? (base_mask << addr_q[1:0]) : 4'b0000;
    end

    // Load extraction: align the addressed lane to bit 0, then sign- or zero-extend.
    always_comb begin
        shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
        load_val = shifted;
        case (op_q[1:0])
            2'b00:   load_val = op_q[2] ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = op_q[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: ack beats timeout in the same REQ cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = in_mem ? REQ : DONE;
            REQ:  if (mem_ack || timeout_hit) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Op capture, timeout counting and result formation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 32'd0;
            sdata_q <= 32'd0;
            op_q    <= 5'd0;
            rd_q    <= 5'd0;
            cnt     <= '0;
            wb_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        addr_q  <= EXU_data;
                        sdata_q <= store_data;
                        op_q    <= lsu_op;
                        rd_q    <= rd_in;
                        cnt     <= '0;
                        if (in_mem) begin
                            wb_q  <= 32'd0;
                            err_q <= 1'b0;
                        end else if (in_kind == KIND_NONE) begin
                            wb_q  <= EXU_data;
                            err_q <= 1'b0;
                        end else begin
                            wb_q  <= 32'd0;
                            err_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        cnt   <= '0;
                        wb_q  <= is_store ? 32'd0 : load_val;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        cnt   <= '0;
                        wb_q  <= 32'd0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized ops against a behavioural reference model.
// Latency: checks edge counts from accept to mem_req/out_valid.
// Backpressure: holds out_ready low and checks DONE outputs stay stable.
module tb_lsu;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] EXU_data;
    logic [31:0] store_data;
    logic [4:0]  lsu_op;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [4:0]  rd_out;
    logic        lsu_err;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .EXU_data(EXU_data), .store_data(store_data), .lsu_op(lsu_op), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .rd_out(rd_out), .lsu_err(lsu_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what one op should do, from the address/size/kind rules.
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input int ack_d,
                         output int e_req_n, output logic [31:0] e_addr, output logic [31:0] e_wdata,
                         output logic e_we, output logic [3:0] e_mask,
                         output logic [31:0] e_wb, output logic e_err);
        int kind, size, nb, idx;
        bit timed;
        longint v;
        kind = int'(op[4:3]);
        size = int'(op[1:0]);
        e_req_n = 0; e_addr = 0; e_wdata = 0; e_we = 0; e_mask = 0; e_wb = 0; e_err = 0;
        if (kind == 0) begin
            e_wb = a;
        end else if (kind == 3 || size == 3) begin
            e_err = 1;
        end else begin
            nb  = 1 << size;
            idx = int'(a % 4);
            if ((a % nb) != 0) begin
                e_err = 1;
            end else begin
                timed   = !(ack_d >= 1 && ack_d <= T);
                e_req_n = timed ? T : ack_d;
                e_addr  = a - idx;
                if (kind == 2) begin
                    e_we    = 1;
                    e_wdata = 32'(longint'(sd) << (8 * idx));
                    e_mask  = 4'(((1 << nb) - 1) << idx);
                end
                if (timed) begin
                    e_err = 1;
                end else if (kind == 1) begin
                    v = (longint'(rdata) >> (8 * idx)) % (longint'(1) << (8 * nb));
                    if (!op[2] && v >= (longint'(1) << (8 * nb - 1)))
                        v = v - (longint'(1) << (8 * nb));
                    e_wb = 32'(v);
                end
            end
        end
    endtask

    // Drives one op through accept, bus phase and delivery; reports what was observed.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input int ack_d, input logic [31:0] rdata,
                          input int rdy_d,
                          output bit acc_ok, output int req_n, output int lat,
                          output logic [31:0] m_addr, output logic [31:0] m_wdata,
                          output logic m_we, output logic [3:0] m_mask,
                          output logic [31:0] wb, output logic [4:0] rdo, output logic err,
                          output bit stable);
        int cycles;
        acc_ok = in_ready;
        stable = 1;
        req_n = 0; m_addr = 0; m_wdata = 0; m_we = 0; m_mask = 0;
        in_valid = 1; EXU_data = a; store_data = sd; lsu_op = op; rd_in = rd;
        step();
        in_valid = 0; EXU_data = $urandom; store_data = $urandom;
        lsu_op = 5'($urandom); rd_in = 5'($urandom);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    m_addr = mem_addr; m_wdata = mem_wdata; m_we = mem_we; m_mask = mem_wmask;
                end else if (mem_addr !== m_addr || mem_wdata !== m_wdata ||
                             mem_we !== m_we || mem_wmask !== m_mask) begin
                    stable = 0;
                end
                if (in_ready) stable = 0;
                mem_ack   = (req_n == ack_d);
                mem_rdata = mem_ack ? rdata : $urandom;
            end
            cycles++;
            step();
            mem_ack = 0;
        end
        lat = out_valid ? cycles + 1 : -1;
        wb = wb_data; rdo = rd_out; err = lsu_err;
        out_ready = 0;
        for (int i = 0; i < rdy_d; i++) begin
            step();
            if (wb_data !== wb || rd_out !== rdo || lsu_err !== err ||
                out_valid !== 1'b1 || in_ready !== 1'b0 || mem_req !== 1'b0)
                stable = 0;
        end
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; out_ready = 0; mem_ack = 0; mem_rdata = 0;
        EXU_data = 0; store_data = 0; lsu_op = 0; rd_in = 0;
        step(); step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0)
            begin errors++; $display("FAIL reset_hs in_ready=%b out_valid=%b mem_req=%b mem_we=%b want 1 0 0 0", in_ready, out_valid, mem_req, mem_we); end
        checks++;
        if (mem_addr !== 0 || mem_wdata !== 0 || mem_wmask !== 0 || wb_data !== 0 || rd_out !== 0 || lsu_err !== 0)
            begin errors++; $display("FAIL reset_data addr=%h wdata=%h mask=%b wb=%h rd=%0d err=%b want all zero", mem_addr, mem_wdata, mem_wmask, wb_data, rd_out, lsu_err); end
        rst = 0;
        step();
    endtask

    task automatic test_passthrough();
        bit acc, st; int rq, lat; logic [31:0] ma, mw, wb; logic we, er; logic [3:0] mk; logic [4:0] rdo;
        run_op(5'b00000, 32'h1234_5678, 32'h0, 5'd5, 0, 32'h0, 1, acc, rq, lat, ma, mw, we, mk, wb, rdo, er, st);
        checks++;
        if (acc !== 1 || rq !== 0 || lat !== 1)
            begin errors++; $display("FAIL pass_timing acc=%0d req=%0d lat=%0d want 1 0 1", acc, rq, lat); end
        checks++;
        if (wb !== 32'h1234_5678 || rdo !== 5'd5 || er !== 1'b0)
            begin errors++; $display("FAIL pass_result wb=%h rd=%0d err=%b want 12345678 5 0", wb, rdo, er); end
    endtask

    task automatic test_load_byte();
        bit acc, st; int rq, lat; logic [31:0] ma, mw, wb; logic we, er; logic [3:0] mk; logic [4:0] rdo;
        run_op(5'b01000, 32'h8000_0003, 32'h0, 5'd7, 3, 32'h80AA_BBCC, 0, acc, rq, lat, ma, mw, we, mk, wb, rdo, er, st);
        checks++;
        if (ma !== 32'h8000_0000 || we !== 1'b0 || mk !== 4'b0000 || rq !== 3 || lat !== 4)
            begin errors++; $display("FAIL lb_bus addr=%h we=%b mask=%b req=%0d lat=%0d want 80000000 0 0000 3 4", ma, we, mk, rq, lat); end
        checks++;
        if (wb !== 32'hFFFF_FF80 || er !== 1'b0 || rdo !== 5'd7)
            begin errors++; $display("FAIL lb_signed wb=%h err=%b rd=%0d want ffffff80 0 7", wb, er, rdo); end
        run_op(5'b01100, 32'h8000_0003, 32'h0, 5'd8, 3, 32'h80AA_BBCC, 0, acc, rq, lat, ma, mw, we, mk, wb, rdo, er, st);
        checks++;
        if (wb !== 32'h0000_0080 || er !== 1'b0)
            begin errors++; $display("FAIL lbu wb=%h err=%b want 00000080 0", wb, er); end
    endtask

    task automatic test_store_half();
        bit acc, st; int rq, lat; logic [31:0] ma, mw, wb; logic we, er; logic [3:0] mk; logic [4:0] rdo;
        run_op(5'b10001, 32'h8000_0102, 32'hDEAD_BEEF, 5'd3, 1, 32'h0, 0, acc, rq, lat, ma, mw, we, mk, wb, rdo, er, st);
        checks++;
        if (ma !== 32'h8000_0100 || we !== 1'b1 || mk !== 4'b1100 || mw !== 32'hBEEF_0000)
            begin errors++; $display("FAIL sh_bus addr=%h we=%b mask=%b wdata=%h want 80000100 1 1100 beef0000", ma, we, mk, mw); end
        checks++;
        if (wb !== 32'h0 || er !== 1'b0 || lat !== 2)
            begin errors++; $display("FAIL sh_result wb=%h err=%b lat=%0d want 0 0 2", wb, er, lat); end
    endtask

    task automatic test_misaligned();
        bit acc, st; int rq, lat; logic [31:0] ma, mw, wb; logic we, er; logic [3:0] mk; logic [4:0] rdo;
        run_op(5'b01010, 32'h8000_0001, 32'h0, 5'd9, 1, 32'h0, 0, acc, rq, lat, ma, mw, we, mk, wb, rdo, er, st);
        checks++;
        if (rq !== 0 || er !== 1'b1 || wb !== 32'h0 || lat !== 1)
            begin errors++; $display("FAIL misaligned req=%0d err=%b wb=%h lat=%0d want 0 1 0 1", rq, er, wb, lat); end
    endtask

    task automatic test_timeout_backpressure();
        bit acc, st; int rq, lat; logic [31:0] ma, mw, wb; logic we, er; logic [3:0] mk; logic [4:0] rdo;
        run_op(5'b01010, 32'h0000_0040, 32'h0, 5'd11, 0, 32'h0, 3, acc, rq, lat, ma, mw, we, mk, wb, rdo, er, st);
        checks++;
        if (rq !== T || lat !== T + 1)
            begin errors++; $display("FAIL timeout_cycles req=%0d lat=%0d want %0d %0d", rq, lat, T, T + 1); end
        checks++;
        if (er !== 1'b1 || wb !== 32'h0 || rdo !== 5'd11)
            begin errors++; $display("FAIL timeout_result err=%b wb=%h rd=%0d want 1 0 11", er, wb, rdo); end
        checks++;
        if (st !== 1)
            begin errors++; $display("FAIL backpressure_stable stable=%0d want 1", st); end
    endtask

    task automatic test_ack_at_timeout();
        bit acc, st; int rq, lat; logic [31:0] ma, mw, wb; logic we, er; logic [3:0] mk; logic [4:0] rdo;
        run_op(5'b01010, 32'h0000_0100, 32'h0, 5'd12, T, 32'hCAFE_F00D, 0, acc, rq, lat, ma, mw, we, mk, wb, rdo, er, st);
        checks++;
        if (rq !== T || er !== 1'b0 || wb !== 32'hCAFE_F00D)
            begin errors++; $display("FAIL ack_wins req=%0d err=%b wb=%h want %0d 0 cafef00d", rq, er, wb, T); end
    endtask

    task automatic test_async_reset();
        in_valid = 1; EXU_data = 32'h0000_0200; lsu_op = 5'b01010; rd_in = 5'd4;
        step();
        in_valid = 0;
        checks++;
        if (mem_req !== 1'b1)
            begin errors++; $display("FAIL areset_pre mem_req=%b want 1", mem_req); end
        #2 rst = 1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL areset_req mem_req=%b in_ready=%b want 0 1", mem_req, in_ready); end
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        #2 rst = 0;
        step();
        mem_ack = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL late_ack in_ready=%b out_valid=%b mem_req=%b want 1 0 0", in_ready, out_valid, mem_req); end
        in_valid = 1; EXU_data = 32'hABCD_0001; lsu_op = 5'b00000; rd_in = 5'd6;
        step();
        in_valid = 0;
        #2 rst = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || wb_data !== 32'h0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL areset_done out_valid=%b wb=%h in_ready=%b want 0 0 1", out_valid, wb_data, in_ready); end
        rst = 0;
        step();
    endtask

    task automatic test_random();
        bit acc, st; int rq, lat; logic [31:0] ma, mw, wb; logic we, er; logic [3:0] mk; logic [4:0] rdo;
        int e_rq; logic [31:0] e_ma, e_mw, e_wb; logic e_we, e_er; logic [3:0] e_mk;
        logic [4:0] op; logic [31:0] a, sd, rdata; logic [4:0] rd; int ack_d, rdy_d, kind;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            op[4:3] = 2'(kind);
            op[2]   = 1'($urandom);
            op[1:0] = (kind == 0) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            sd = $urandom; rdata = $urandom; rd = 5'($urandom);
            ack_d = $urandom_range(1, T + 1);
            rdy_d = $urandom_range(0, 2);
            model(op, a, sd, rdata, ack_d, e_rq, e_ma, e_mw, e_we, e_mk, e_wb, e_er);
            run_op(op, a, sd, rd, ack_d, rdata, rdy_d, acc, rq, lat, ma, mw, we, mk, wb, rdo, er, st);
            checks++;
            if (acc !== 1 || rq !== e_rq || lat !== e_rq + 1)
                begin errors++; $display("FAIL rnd_timing op=%b a=%h acc=%0d req=%0d lat=%0d want 1 %0d %0d", op, a, acc, rq, lat, e_rq, e_rq + 1); end
            checks++;
            if (ma !== e_ma || mw !== e_mw || we !== e_we || mk !== e_mk)
                begin errors++; $display("FAIL rnd_bus op=%b a=%h addr=%h wdata=%h we=%b mask=%b want %h %h %b %b", op, a, ma, mw, we, mk, e_ma, e_mw, e_we, e_mk); end
            checks++;
            if (wb !== e_wb || er !== e_er || rdo !== rd)
                begin errors++; $display("FAIL rnd_result op=%b a=%h rdata=%h wb=%h err=%b rd=%0d want %h %b %0d", op, a, rdata, wb, er, rdo, e_wb, e_er, rd); end
            checks++;
            if (st !== 1)
                begin errors++; $display("FAIL rnd_stable op=%b a=%h stable=%0d want 1", op, a, st); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout_backpressure();
        test_ack_at_timeout();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the number of REQ-state cycles without mem_ack before a bus error is declared.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream (EXU) result valid.
REQ-005 in_ready  output  1  stage can accept a new op.
REQ-006 EXU_data  input  32  ALU result: effective address for memory ops, write-back value otherwise.
REQ-007 store_data  input  32  rs2 value for stores.
REQ-008 lsu_op  input  5  [4:3] kind (00 none, 01 load, 10 store, 11 reserved); [2] unsigned load; [1:0] size (00 byte, 01 half, 10 word, 11 reserved).
REQ-009 rd_in  input  5  destination register index.
REQ-010 mem_req, mem_we  output  1 each  bus request; write enable.
REQ-011 mem_addr  output  32  word-aligned bus address.
REQ-012 mem_wdata  output  32  lane-aligned store data.
REQ-013 mem_wmask  output  4  byte-lane write strobes.
REQ-014 mem_ack  input  1  bus completion, sampled only in REQ.
REQ-015 mem_rdata  input  32  read data, valid with mem_ack.
REQ-016 out_valid  output  1  write-back result valid.
REQ-017 out_ready  input  1  downstream (WBU) accepts result.
REQ-018 wb_data  output  32  write-back value.
REQ-019 rd_out  output  5  captured rd_in.
REQ-020 lsu_err  output  1  misaligned access, reserved encoding, or bus timeout.

Function
REQ-021 FSM states SHALL be IDLE, REQ, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE, mem_req=1 only in REQ.
REQ-022 IDLE with in_valid SHALL capture EXU_data, store_data, lsu_op and rd_in, then go to REQ for a legal aligned load/store, otherwise to DONE.
REQ-023 Kind 00 SHALL give wb_data=EXU_data, lsu_err=0; kind 11 or size 11 SHALL give wb_data=0, lsu_err=1, with no bus access.
REQ-024 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) SHALL give wb_data=0, lsu_err=1, with no bus access.
REQ-025 In REQ, mem_addr SHALL be {addr[31:2],2'b00}, and mem_we, mem_wdata and mem_wmask SHALL stay stable until mem_ack.
REQ-026 Store lane placement: mem_wdata = store_data << (8*addr[1:0]); mem_wmask = (0001 byte, 0011 half, 1111 word) << addr[1:0]; mem_wmask=0 for loads.
REQ-027 Load extraction: shift mem_rdata right by 8*addr[1:0], take the byte/half/word, and sign-extend (lsu_op[2]=0) or zero-extend (lsu_op[2]=1) to 32 bits.
REQ-028 Store completion SHALL give wb_data=0, lsu_err=0.
REQ-029 On mem_ack in REQ: capture the result, clear the timeout counter, go to DONE next edge.
REQ-030 The timeout counter SHALL increment each REQ cycle without mem_ack; on reaching TIMEOUT it SHALL go to DONE with lsu_err=1, wb_data=0.
REQ-031 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, mem_ack SHALL win.
REQ-032 DONE SHALL hold wb_data, rd_out and lsu_err stable until out_ready=1, then return to IDLE; there is no accept/deliver overlap (one op in flight).
REQ-033 Latency from accept edge: non-memory/error ops give out_valid after 1 edge; memory ops give mem_req after 1 edge and out_valid 1 edge after the acked cycle.

Reset
REQ-034 rst SHALL force IDLE and zero all outputs except in_ready=1, and clear the counter and captured registers.
REQ-035 rst mid-REQ or mid-DONE SHALL drop mem_req/out_valid immediately, without waiting for a clock edge; a late mem_ack after reset SHALL be ignored.

Verification
REQ-036 Pass-through: lsu_op=00000, EXU_data=0x1234_5678, rd_in=5 -> out_valid next cycle, wb_data=0x1234_5678, rd_out=5, no mem_req.
REQ-037 Signed byte load: addr=0x8000_0003, lsu_op=01000, mem_rdata=0x80AA_BBCC with ack after 3 cycles -> mem_addr=0x8000_0000, wb_data=0xFFFF_FF80; unsigned (01100) -> 0x0000_0080.
REQ-038 Half store: addr=0x8000_0102, store_data=0xDEAD_BEEF, lsu_op=10001 -> mem_we=1, mem_wmask=1100, mem_wdata=0xBEEF_0000, wb_data=0.
REQ-039 Misaligned word load: addr=0x8000_0001, lsu_op=01010 -> no mem_req, lsu_err=1, wb_data=0.
REQ-040 Timeout and backpressure: never ack with TIMEOUT=4 -> mem_req high for 4 cycles, then lsu_err=1; hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0 throughout.
REQ-041 Async reset during REQ -> mem_req=0 before the next edge, state IDLE, in_ready=1.
